// File: rtl/lfsr_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker_if
//  Description : Valid-qualified 8-bit word bus feeding the LFSR checker.
//                master drives in_valid/in_data, slave (the checker) samples.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_checker_if;
    logic       in_valid;   // in_data valid this cycle
    logic [7:0] in_data;    // received LFSR word

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);
endinterface : lfsr_checker_if
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker
//  Description : Receive-side checker for the 8-bit LFSR pattern generator.
//                Self-synchronises by seeding from received words (HUNT/SYNC),
//                then flywheels its own prediction while LOCKED, flagging
//                mismatches and keeping a saturating error count.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                bus (slave)       - in_valid / in_data word stream
//                clr               - synchronous clear of err_count/err_sticky
//                locked            - high while LOCKED
//                err_pulse         - one cycle per mismatched word in LOCKED
//                err_sticky        - set on first mismatch, held until clr/rst
//                err_count         - saturating mismatch count (CNT_W bits)
//                seg_o             - only with LFSR_CHK_DISP_EN: err_count[7:0]
//                                    as two seven-segment digits
//  Options     : `define LFSR_CHK_DISP_EN to add the seg_o display port.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int LOCK_CNT = 4,     // 2..15 matching words to lock
    parameter int LOSS_CNT = 3,     // 1..15 consecutive misses to lose lock
    parameter int CNT_W    = 16     // err_count width, >= 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    lfsr_checker_if.slave         bus,
    input  wire logic             clr,
    output logic                  locked,
    output logic                  err_pulse,
    output logic                  err_sticky,
`ifdef LFSR_CHK_DISP_EN
    output logic [CNT_W-1:0]      err_count,
    output logic [15:0]           seg_o
`else
    output logic [CNT_W-1:0]      err_count
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
    localparam logic [3:0]       c_loss_cnt = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[4] ^ d[3] ^ d[2] ^ d[0], d[7:1]};
    endfunction

    state_t             state_q,      state_d;
    logic [7:0]         pred_q,       pred_d;
    logic [3:0]         match_cnt_q,  match_cnt_d;
    logic [3:0]         miss_cnt_q,   miss_cnt_d;
    logic               locked_q,     locked_d;
    logic               err_pulse_q,  err_pulse_d;
    logic               err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]   err_count_q,  err_count_d;

    logic [3:0]         w_match_inc;
    logic [3:0]         w_miss_inc;
    logic [7:0]         w_data;

    assign w_data      = bus.in_data;
    assign w_match_inc = match_cnt_q + 4'd1;
    assign w_miss_inc  = miss_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        pred_d       = pred_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (bus.in_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    // All-zero is the LFSR lock-up value, never a usable seed.
                    if (w_data != 8'h00) begin
                        pred_d      = lfsr_next(w_data);
                        match_cnt_d = 4'd1;
                        state_d     = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    // pred is never zero here, so an equal word is nonzero too.
                    if (w_data == pred_q) begin
                        match_cnt_d = w_match_inc;
                        pred_d      = lfsr_next(w_data);
                        if (w_match_inc == c_lock_cnt) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end
                    end else if (w_data != 8'h00) begin
                        pred_d      = lfsr_next(w_data);
                        match_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: prediction runs from itself, never from data.
                    pred_d = lfsr_next(pred_q);
                    if (w_data == pred_q) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_count_q != c_cnt_max) begin
                            err_count_d = err_count_q + c_cnt_one;
                        end
                        miss_cnt_d = w_miss_inc;
                        if (w_miss_inc == c_loss_cnt) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // clr overrides a coincident error update; err_pulse is unaffected.
        if (clr) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            pred_q       <= 8'h00;
            match_cnt_q  <= 4'd0;
            miss_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

`ifdef LFSR_CHK_DISP_EN
    bcd7seg u_seg_lo (.bcd(err_count_q[3:0]), .seg(seg_o[7:0]));
    bcd7seg u_seg_hi (.bcd(err_count_q[7:4]), .seg(seg_o[15:8]));
`endif

endmodule : lfsr_checker

`ifdef LFSR_CHK_DISP_EN
// ============================================================================
//  Module      : bcd7seg
//  Description : Nibble to seven-segment decode, seg = {dp,g,f,e,d,c,b,a},
//                active-high, dp off; A..F shown as hex letters.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd7seg (
    input  wire logic [3:0] bcd,
    output logic      [7:0] seg
);
    always_comb begin
        seg = 8'h00;
        unique case (bcd)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
            default: seg = 8'h00;
        endcase
    end
endmodule : bcd7seg
`endif
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_checker
//  Description : Self-checking bench for lfsr_checker. Two instances share one
//                stimulus bus: u_dut0 (defaults) and u_dut1 (CNT_W=8,
//                LOSS_CNT=15). A behavioural model pushes expected outputs per
//                driven cycle; they are popped and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic clr = 1'b0;
    lfsr_checker_if bus ();

    logic        l0, p0, s0;
    logic [15:0] c0;
    logic        l1, p1, s1;
    logic [7:0]  c1;
`ifdef LFSR_CHK_DISP_EN
    logic [15:0] seg0, seg1;
`endif

    lfsr_checker u_dut0 (
        .clk(clk), .rst(rst), .bus(bus), .clr(clr),
        .locked(l0), .err_pulse(p0), .err_sticky(s0),
`ifdef LFSR_CHK_DISP_EN
        .err_count(c0), .seg_o(seg0)
`else
        .err_count(c0)
`endif
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus), .clr(clr),
        .locked(l1), .err_pulse(p1), .err_sticky(s1),
`ifdef LFSR_CHK_DISP_EN
        .err_count(c1), .seg_o(seg1)
`else
        .err_count(c1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model (one slot per instance) ----------------
    typedef struct packed {
        logic        lk;
        logic        pl;
        logic        sk;
        logic [15:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int         m_st   [2];   // 0 hunt, 1 sync, 2 locked
    int         m_mc   [2];
    int         m_mm   [2];
    int         m_cnt  [2];
    logic [7:0] m_pred [2];
    bit         m_pl   [2];
    bit         m_sk   [2];
    int         m_loss [2] = '{3, 15};
    int         m_max  [2] = '{65535, 255};

    function automatic logic [7:0] tb_next(input logic [7:0] d);
        logic fb;
        fb = ^(d & 8'b0001_1101);
        return {fb, d[7:1]};
    endfunction

    function automatic void model_step(input int k, input bit r, input bit v,
                                       input logic [7:0] d, input bit c);
        logic [7:0] e;
        if (r) begin
            m_st[k] = 0; m_mc[k] = 0; m_mm[k] = 0; m_cnt[k] = 0;
            m_pred[k] = 8'h00; m_pl[k] = 0; m_sk[k] = 0;
            return;
        end
        m_pl[k] = 0;
        if (v) begin
            if (m_st[k] == 0) begin
                if (d != 0) begin m_pred[k] = tb_next(d); m_mc[k] = 1; m_st[k] = 1; end
            end else if (m_st[k] == 1) begin
                if (d == m_pred[k]) begin
                    m_mc[k]++; m_pred[k] = tb_next(d);
                    if (m_mc[k] == 4) begin m_st[k] = 2; m_mm[k] = 0; end
                end else if (d != 0) begin
                    m_pred[k] = tb_next(d); m_mc[k] = 1;
                end else m_st[k] = 0;
            end else begin
                e = m_pred[k];
                m_pred[k] = tb_next(e);
                if (d == e) m_mm[k] = 0;
                else begin
                    m_pl[k] = 1; m_sk[k] = 1;
                    if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                    m_mm[k]++;
                    if (m_mm[k] == m_loss[k]) m_st[k] = 0;
                end
            end
        end
        if (c) begin m_cnt[k] = 0; m_sk[k] = 0; end
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t x;
        x.lk  = (m_st[k] == 2);
        x.pl  = m_pl[k];
        x.sk  = m_sk[k];
        x.cnt = 16'(m_cnt[k]);
        return x;
    endfunction

    // One driven cycle: drive, predict, clock, then compare both instances.
    task automatic beat(input bit r, input bit v, input logic [7:0] d, input bit c);
        exp_t e;
        rst = r; bus.in_valid = v; bus.in_data = d; clr = c;
        for (int k = 0; k < 2; k++) model_step(k, r, v, d, c);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        @(posedge clk);
        #1;
        e = q0.pop_front();
        check("d0_locked", l0, e.lk);
        check("d0_pulse",  p0, e.pl);
        check("d0_sticky", s0, e.sk);
        check("d0_count",  c0, e.cnt);
        e = q1.pop_front();
        check("d1_locked", l1, e.lk);
        check("d1_pulse",  p1, e.pl);
        check("d1_sticky", s1, e.sk);
        check("d1_count",  c1, e.cnt);
    endtask

    task automatic vbeat(input logic [7:0] d);
        beat(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        beat(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic lock_seq(input bit gaps);
        logic [7:0] seq [4] = '{8'h01, 8'h80, 8'h40, 8'h20};
        for (int i = 0; i < 4; i++) begin
            vbeat(seq[i]);
            if (gaps) begin
                beat(1'b0, 1'b0, 8'hA5, 1'b0);
                beat(1'b0, 1'b0, 8'h00, 1'b0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        do_reset();
        check("rst_locked", l0, 0);
        check("rst_count",  c0, 0);

        // 1. Lock on 01,80,40,20
        vbeat(8'h01); vbeat(8'h80); vbeat(8'h40);
        check("t1_not_locked_3rd", l0, 0);
        vbeat(8'h20);
        check("t1_locked", l0, 1);
        check("t1_count",  c0, 0);

        // 2. Single error: 10, 00 (expected 88), C4
        vbeat(8'h10);
        vbeat(8'h00);
        check("t2_pulse",  p0, 1);
        check("t2_count",  c0, 1);
        check("t2_sticky", s0, 1);
        vbeat(8'hC4);
        check("t2_pulse_gone", p0, 0);
        check("t2_still_locked", l0, 1);

        // 3. Loss after 3 consecutive misses, then relock
        do_reset();
        lock_seq(1'b0);
        vbeat(8'h10); vbeat(8'h88); vbeat(8'hC4);
        vbeat(8'h55); vbeat(8'h55);
        check("t3_locked_2miss", l0, 1);
        vbeat(8'h55);
        check("t3_count", c0, 3);
        check("t3_lost",  l0, 0);
        check("t3_d1_held", l1, 1);
        lock_seq(1'b0);
        check("t3_relock", l0, 1);

        // 4. Zeros ignored in HUNT; zero mid-SYNC returns to HUNT
        do_reset();
        vbeat(8'h00); vbeat(8'h00);
        lock_seq(1'b0);
        check("t4_locked", l0, 1);
        do_reset();
        vbeat(8'h01); vbeat(8'h80); vbeat(8'h00); vbeat(8'h40); vbeat(8'h20);
        check("t4_no_lock", l0, 0);

        // 5. Gaps are transparent; clr wins over a coincident mismatch
        do_reset();
        lock_seq(1'b1);
        check("t5_gap_locked", l0, 1);
        vbeat(8'h00); vbeat(8'h88); vbeat(8'h00);
        check("t5_count2", c0, 2);
        beat(1'b0, 1'b1, 8'h00, 1'b1);
        check("t5_clr_count",  c0, 0);
        check("t5_clr_sticky", s0, 0);
        check("t5_clr_pulse",  p0, 1);

        // 6. Saturation on the 8-bit instance, then mid-stream reset
        do_reset();
        lock_seq(1'b0);
        p = 8'h10;
        for (int i = 0; i < 300; i++) begin
            vbeat(8'h00);
            p = tb_next(p);
            vbeat(p);
            p = tb_next(p);
        end
        check("t6_sat_count", c1, 255);
        check("t6_wide_count", c0, 300);
        check("t6_d1_locked", l1, 1);
        beat(1'b1, 1'b1, p, 1'b0);
        check("t6_rst_locked", l1, 0);
        check("t6_rst_count",  c1, 0);
        check("t6_rst_sticky", s1, 0);
        check("t6_rst_pulse",  p0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lfsr_checker
`default_nettype wire
